// File: rtl/multi_axis_cmd_fsm.sv
`default_nettype none
// ============================================================================
// Module      : multi_axis_cmd_fsm
// Description : SPI command decoder for NUM_AXES coordinated stepper axes.
//               Decodes 64-bit command words, stages multi-word coordinated
//               moves and commits each move atomically into a DEPTH-slot
//               move ring using stepready/stepfinished toggle handshakes.
// Ports       : CLK, resetn         - clock, asynchronous active-low reset
//               word_received       - word strobe level (may be asynchronous)
//               word_data           - received SPI word
//               encoder_count       - per-axis 64-bit encoder positions
//               stepfinished        - per-slot completion toggles from DDAs
//               word_send_data      - reply word for the next SPI transfer
//               move_wr/_addr       - single-cycle commit strobe and slot
//               move_duration/_increment/_incinc/_dir - staged move fields
//               stepready           - per-slot ready toggles
//               enable              - per-axis driver enables
//               clock_divisor       - DDA tick divisor
// Revision    : 1.0 - initial release
// ============================================================================
module multi_axis_cmd_fsm #(
    parameter int          NUM_AXES    = 3,
    parameter int          BUFFER_BITS = 2,
    parameter logic [23:0] VERSION     = 24'h000100,
    parameter logic [7:0]  DIV_RESET   = 8'd40,
    localparam int         DEPTH       = 2**BUFFER_BITS
) (
    input  logic                     CLK,
    input  logic                     resetn,
    input  logic                     word_received,
    input  logic [63:0]              word_data,
    input  logic [64*NUM_AXES-1:0]   encoder_count,
    input  logic [DEPTH-1:0]         stepfinished,
    output logic [63:0]              word_send_data,
    output logic                     move_wr,
    output logic [BUFFER_BITS-1:0]   move_wr_addr,
    output logic [63:0]              move_duration,
    output logic [64*NUM_AXES-1:0]   move_increment,
    output logic [64*NUM_AXES-1:0]   move_incinc,
    output logic [NUM_AXES-1:0]      move_dir,
    output logic [DEPTH-1:0]         stepready,
    output logic [NUM_AXES-1:0]      enable,
    output logic [7:0]               clock_divisor
);

    localparam int         IDX_W       = 5;
    localparam logic [7:0] HDR_STEP    = 8'h01;
    localparam logic [7:0] HDR_ENABLE  = 8'h0A;
    localparam logic [7:0] HDR_DIVISOR = 8'h0B;
    localparam logic [7:0] HDR_STATUS  = 8'h0C;
    localparam logic [7:0] HDR_VERSION = 8'hFE;

    typedef enum logic [1:0] {
        S_IDLE         = 2'd0,
        S_MOVE         = 2'd1,
        S_STATUS_TAIL  = 2'd2,
        S_VERSION_TAIL = 2'd3
    } state_t;

    state_t                   r_state;
    state_t                   w_state_nxt;

    logic [1:0]               r_sync;
    logic                     r_sync_d;
    logic                     w_wr_p;
    logic [7:0]               w_hdr;
    logic                     w_last;

    logic [IDX_W-1:0]         r_idx;
    logic                     r_commit;
    logic [DEPTH-1:0]         r_sf;
    logic [DEPTH-1:0]         r_stepready;
    logic [BUFFER_BITS-1:0]   r_wr_ptr;
    logic                     r_ovf;
    logic [7:0]               r_ovf_cnt;
    logic [7:0]               r_unknown_cnt;
    logic [64*NUM_AXES-1:0]   r_enc_snap;

    logic [63:0]              r_send;
    logic                     r_move_wr;
    logic [BUFFER_BITS-1:0]   r_move_wr_addr;
    logic [63:0]              r_move_duration;
    logic [64*NUM_AXES-1:0]   r_move_increment;
    logic [64*NUM_AXES-1:0]   r_move_incinc;
    logic [NUM_AXES-1:0]      r_move_dir;
    logic [NUM_AXES-1:0]      r_enable;
    logic [7:0]               r_clock_divisor;

    logic [DEPTH-1:0]         w_busy;
    logic                     w_slot_busy;
    logic [63:0]              w_status;

    // Word strobe: two-flop synchroniser followed by rising-edge detect.
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            r_sync   <= 2'b00;
            r_sync_d <= 1'b0;
        end else begin
            r_sync   <= {r_sync[0], word_received};
            r_sync_d <= r_sync[1];
        end
    end

    assign w_wr_p = r_sync[1] & ~r_sync_d;
    assign w_hdr  = word_data[63:56];
    assign w_last = (r_idx == IDX_W'(2*NUM_AXES));

    // A slot is busy while its ready toggle differs from its finished toggle.
    assign w_busy      = r_stepready ^ r_sf;
    assign w_slot_busy = w_busy[r_wr_ptr];

    always_comb begin
        w_status                 = '0;
        w_status[63:56]          = r_ovf_cnt;
        w_status[DEPTH-1+8:8]    = w_busy;
        w_status[0]              = r_ovf;
    end

    // FSM state register
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) r_state <= S_IDLE;
        else         r_state <= w_state_nxt;
    end

    // FSM next-state logic
    always_comb begin
        w_state_nxt = r_state;
        if (w_wr_p) begin
            case (r_state)
                S_IDLE: begin
                    case (w_hdr)
                        HDR_STEP:    w_state_nxt = S_MOVE;
                        HDR_STATUS:  w_state_nxt = S_STATUS_TAIL;
                        HDR_VERSION: w_state_nxt = S_VERSION_TAIL;
                        default:     w_state_nxt = S_IDLE;
                    endcase
                end
                S_MOVE:  if (w_last) w_state_nxt = S_IDLE;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // Datapath: command decode, move staging and ring commit
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            r_idx            <= '0;
            r_commit         <= 1'b0;
            r_sf             <= '0;
            r_stepready      <= '0;
            r_wr_ptr         <= '0;
            r_ovf            <= 1'b0;
            r_ovf_cnt        <= 8'd0;
            r_unknown_cnt    <= 8'd0;
            r_enc_snap       <= '0;
            r_send           <= '0;
            r_move_wr        <= 1'b0;
            r_move_wr_addr   <= '0;
            r_move_duration  <= '0;
            r_move_increment <= '0;
            r_move_incinc    <= '0;
            r_move_dir       <= '0;
            r_enable         <= '0;
            r_clock_divisor  <= DIV_RESET;
        end else begin
            r_move_wr <= 1'b0;
            r_commit  <= 1'b0;
            r_sf      <= stepfinished;

            if (w_wr_p) begin
                r_send <= '0;
                case (r_state)
                    S_IDLE: begin
                        case (w_hdr)
                            HDR_STEP: begin
                                r_move_dir <= word_data[NUM_AXES-1:0];
                                r_enc_snap <= encoder_count;
                                r_idx      <= '0;
                            end
                            HDR_ENABLE:  r_enable        <= word_data[NUM_AXES-1:0];
                            HDR_DIVISOR: r_clock_divisor <= word_data[7:0];
                            HDR_STATUS: begin
                                r_send <= w_status;
                                r_ovf  <= 1'b0;
                            end
                            HDR_VERSION: r_send <= {40'd0, VERSION};
                            default: begin
                                if (r_unknown_cnt != 8'hFF)
                                    r_unknown_cnt <= r_unknown_cnt + 8'd1;
                            end
                        endcase
                    end
                    S_MOVE: begin
                        if (r_idx == '0)
                            r_move_duration <= word_data;
                        for (int k = 0; k < NUM_AXES; k++) begin
                            if (r_idx == IDX_W'(2*k+1)) begin
                                r_move_increment[k*64 +: 64] <= word_data;
                                r_send <= r_enc_snap[k*64 +: 64];
                            end
                            if (r_idx == IDX_W'(2*k+2))
                                r_move_incinc[k*64 +: 64] <= word_data;
                        end
                        r_idx <= r_idx + 1'b1;
                        if (w_last)
                            r_commit <= 1'b1;
                    end
                    default: ;
                endcase
            end

            // Commit one cycle after the final data word; placed last so an
            // overflow set here takes precedence over any sticky clear above.
            if (r_commit) begin
                if (!w_slot_busy) begin
                    r_move_wr             <= 1'b1;
                    r_move_wr_addr        <= r_wr_ptr;
                    r_stepready[r_wr_ptr] <= ~r_stepready[r_wr_ptr];
                    r_wr_ptr              <= r_wr_ptr + 1'b1;
                end else begin
                    r_ovf <= 1'b1;
                    if (r_ovf_cnt != 8'hFF)
                        r_ovf_cnt <= r_ovf_cnt + 8'd1;
                end
            end
        end
    end

    assign word_send_data = r_send;
    assign move_wr        = r_move_wr;
    assign move_wr_addr   = r_move_wr_addr;
    assign move_duration  = r_move_duration;
    assign move_increment = r_move_increment;
    assign move_incinc    = r_move_incinc;
    assign move_dir       = r_move_dir;
    assign stepready      = r_stepready;
    assign enable         = r_enable;
    assign clock_divisor  = r_clock_divisor;

endmodule
`default_nettype wire
